// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter/sequencer sharing one registered adder
// among g_num_req requesters, with a watchdog on the adder response.
module adder_arbiter #(
  parameter int g_data_width = 3,
  parameter int g_num_req    = 4,
  parameter int g_timeout    = 8,
  localparam int IW          = $clog2(g_num_req),
  localparam int W           = g_data_width
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [g_num_req-1:0]   i_req_valid,
  input  logic [g_num_req*W-1:0] i_req_A,
  input  logic [g_num_req*W-1:0] i_req_B,
  output logic [g_num_req-1:0]   o_req_ready,
  output logic                   o_add_valid,
  output logic [W-1:0]           o_add_A,
  output logic [W-1:0]           o_add_B,
  input  logic                   i_add_valid,
  input  logic [W:0]             i_add_C,
  output logic                   o_rsp_valid,
  output logic [IW-1:0]          o_rsp_id,
  output logic [W:0]             o_rsp_C,
  output logic                   o_rsp_err,
  input  logic                   i_rsp_ready
);

  localparam int CW = $clog2(g_timeout + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  last_grant_q, last_grant_d;
  logic [IW-1:0]  id_q, id_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W:0]     c_q, c_d;
  logic           err_q, err_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           add_valid_q, add_valid_d;
  logic           rsp_valid_q, rsp_valid_d;

  logic           found_s;
  logic [IW-1:0]  pick_s;
  logic [IW-1:0]  cand_s;
  logic           accept_s;

  // Round-robin search: first valid requester starting after last_grant.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    cand_s  = '0;
    for (int i = 1; i <= g_num_req; i++) begin
      cand_s = IW'((int'(last_grant_q) + i) % g_num_req);
      if (!found_s && i_req_valid[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot grant, only offered in IDLE and never while reset is asserted.
  always_comb begin
    o_req_ready = '0;
    accept_s    = 1'b0;
    if (state_q == S_IDLE && !i_rst && found_s) begin
      o_req_ready[pick_s] = 1'b1;
      accept_s            = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Next-state and datapath logic for the IDLE/ISSUE/WAIT/RESP sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    add_valid_d  = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          a_d          = i_req_A[pick_s*W +: W];
          b_d          = i_req_B[pick_s*W +: W];
          id_d         = pick_s;
          last_grant_d = pick_s;
          add_valid_d  = 1'b1;
          state_d      = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_add_valid) begin
          c_d         = i_add_C;
          err_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (cnt_q == CW'(g_timeout)) begin
          c_d         = '0;
          err_d       = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= IW'(g_num_req - 1);
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      add_valid_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      add_valid_q  <= add_valid_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign o_add_valid = add_valid_q;
  assign o_add_A     = a_q;
  assign o_add_B     = b_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = id_q;
  assign o_rsp_C     = c_q;
  assign o_rsp_err   = err_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Testbench for adder_arbiter: registered adder stub plus response scoreboard.
module tb_adder_arbiter;

  localparam int W  = 3;
  localparam int N  = 4;
  localparam int TO = 8;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N-1:0]     req_ready;
  logic             add_valid_o;
  logic [W-1:0]     add_a;
  logic [W-1:0]     add_b;
  logic             add_valid_i;
  logic [W:0]       add_c;
  logic             rsp_valid;
  logic [IW-1:0]    rsp_id;
  logic [W:0]       rsp_c;
  logic             rsp_err;
  logic             rsp_ready;

  logic             adder_en;
  logic             stray;
  logic             stub_valid_r;
  logic [W:0]       stub_c_r;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [IW-1:0] id;
    logic [W:0]    c;
    logic          err;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  adder_arbiter #(.g_data_width(W), .g_num_req(N), .g_timeout(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_A(req_a), .i_req_B(req_b),
    .o_req_ready(req_ready),
    .o_add_valid(add_valid_o), .o_add_A(add_a), .o_add_B(add_b),
    .i_add_valid(add_valid_i), .i_add_C(add_c),
    .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_C(rsp_c),
    .o_rsp_err(rsp_err), .i_rsp_ready(rsp_ready)
  );

  // Registered adder stub sharing the arbiter reset; adder_en=0 models a dead adder.
  always_ff @(posedge clk) begin
    if (rst) begin
      stub_valid_r <= 1'b0;
      stub_c_r     <= '0;
    end else begin
      stub_valid_r <= add_valid_o & adder_en;
      stub_c_r     <= {1'b0, add_a} + {1'b0, add_b};
    end
  end
  assign add_valid_i = stub_valid_r | stray;
  assign add_c       = stray ? 4'd9 : stub_c_r;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int id, input int c, input int err);
    exp_t e;
    e.id  = IW'(id);
    e.c   = (W+1)'(c);
    e.err = err[0];
    exp_q.push_back(e);
  endtask

  task automatic set_op(input int k, input int a, input int b);
    req_a[k*W +: W] = W'(a);
    req_b[k*W +: W] = W'(b);
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every completed response handshake is matched against the queue.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("rsp_id",  32'(rsp_id),  32'(e.id));
        check_eq("rsp_C",   32'(rsp_c),   32'(e.c));
        check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    adder_en = 1'b1;
    stray = 1'b0;

    // Reset with all requesters valid; fairness operands (k, k+1).
    for (int k = 0; k < N; k++) set_op(k, k, k + 1);
    req_valid = '1;
    for (int r = 0; r < 3; r++) begin
      next_cyc();
      @(negedge clk);
      check_eq("reset_outputs",
               32'({req_ready, add_valid_o, add_a, add_b, rsp_valid, rsp_id, rsp_c, rsp_err}),
               32'd0);
    end

    // Fairness: grants 0,1,2,3,0 at 4-cycle spacing, sums 1,3,5,7,1.
    push_exp(0, 1, 0); push_exp(1, 3, 0); push_exp(2, 5, 0);
    push_exp(3, 7, 0); push_exp(0, 1, 0);
    for (int j = 0; j < 20; j++) begin
      next_cyc();
      if (j == 0) rst = 1'b0;
      if (j == 17) req_valid = '0;
      @(negedge clk);
      check_eq("fair_ready", 32'(req_ready),
               (j % 4 == 0 && j <= 16) ? (32'd1 << ((j / 4) % 4)) : 32'd0);
      check_eq("fair_add_valid", 32'(add_valid_o), (j % 4 == 1) ? 32'd1 : 32'd0);
      check_eq("fair_rsp_valid", 32'(rsp_valid), (j % 4 == 3) ? 32'd1 : 32'd0);
    end

    // Single request from requester 2 with the maximum operands.
    set_op(2, 7, 7);
    push_exp(2, 14, 0);
    next_cyc(); req_valid = 4'b0100;
    @(negedge clk); check_eq("single_ready", 32'(req_ready), 32'h4);
    next_cyc(); req_valid = '0;
    @(negedge clk);
    check_eq("single_add_valid", 32'(add_valid_o), 32'd1);
    check_eq("single_add_A", 32'(add_a), 32'd7);
    check_eq("single_add_B", 32'(add_b), 32'd7);
    next_cyc(); @(negedge clk); check_eq("single_rsp_early", 32'(rsp_valid), 32'd0);
    next_cyc(); @(negedge clk); check_eq("single_rsp_valid", 32'(rsp_valid), 32'd1);
    next_cyc();

    // Backpressure: requester 1, response held for 5 cycles.
    set_op(1, 3, 2);
    push_exp(1, 5, 0);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    @(negedge clk); check_eq("bp_ready", 32'(req_ready), 32'h2);
    next_cyc(); req_valid = 4'b1000;
    next_cyc();
    for (int j = 0; j < 5; j++) begin
      next_cyc();
      @(negedge clk);
      check_eq("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("bp_rsp_id", 32'(rsp_id), 32'd1);
      check_eq("bp_rsp_C", 32'(rsp_c), 32'd5);
      check_eq("bp_req_ready", 32'(req_ready), 32'd0);
      check_eq("bp_add_valid", 32'(add_valid_o), 32'd0);
    end
    next_cyc(); rsp_ready = 1'b1; req_valid = '0;
    @(negedge clk); check_eq("bp_complete_valid", 32'(rsp_valid), 32'd1);
    next_cyc(); @(negedge clk); check_eq("bp_drop", 32'(rsp_valid), 32'd0);

    // Timeout: dead adder, requester 3; response TO+1 cycles after WAIT entry.
    adder_en = 1'b0;
    set_op(3, 5, 6);
    push_exp(3, 0, 1);
    next_cyc(); req_valid = 4'b1000;
    @(negedge clk); check_eq("to_ready", 32'(req_ready), 32'h8);
    next_cyc(); req_valid = '0;
    for (int j = 2; j <= 10; j++) begin
      next_cyc();
      @(negedge clk); check_eq("to_wait_quiet", 32'(rsp_valid), 32'd0);
    end
    next_cyc(); stray = 1'b1;
    @(negedge clk); check_eq("to_rsp_valid", 32'(rsp_valid), 32'd1);
    next_cyc();
    @(negedge clk); check_eq("to_stray_idle", 32'(rsp_valid), 32'd0);
    next_cyc(); stray = 1'b0;
    @(negedge clk); check_eq("to_stray_after", 32'(rsp_valid), 32'd0);
    adder_en = 1'b1;

    // Reset during WAIT discards the operation and restores index 0 priority.
    set_op(0, 2, 3);
    next_cyc(); req_valid = 4'b0001;
    @(negedge clk); check_eq("rw_ready", 32'(req_ready), 32'h1);
    next_cyc(); req_valid = '0;
    next_cyc(); rst = 1'b1;
    @(negedge clk); check_eq("rw_ready_in_rst", 32'(req_ready), 32'd0);
    next_cyc(); rst = 1'b0;
    set_op(0, 1, 1);
    push_exp(0, 2, 0);
    req_valid = 4'b0011;
    @(negedge clk);
    check_eq("rw_no_rsp", 32'(rsp_valid), 32'd0);
    check_eq("rw_first_grant", 32'(req_ready), 32'h1);
    next_cyc(); req_valid = '0;

    // Drain the scoreboard within a bounded number of cycles.
    for (int j = 0; j < 20 && exp_q.size() != 0; j++) next_cyc();
    repeat (4) next_cyc();
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one registered adder (one-cycle latency, `g_data_width`-bit operands, `g_data_width+1`-bit sum) among `g_num_req` requesters. It accepts one operand pair at a time and drives the adder's valid/operand inputs. It captures the adder result and returns it with the requester ID over a valid/ready response channel. A watchdog flags an adder that never answers.

## Interface
- `g_data_width`, default 3: operand width W; sum width is W+1.
- `g_num_req`, default 4: number of requesters N (N ≥ 2).
- `g_timeout`, default 8: maximum WAIT cycles before the error response.
- ID width IW = $clog2(N).

Ports:
- `i_clk`  in  1  single clock; all logic on rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_req_valid`  in  N  per-requester request valid.
- `i_req_A`  in  N*W  packed operand A; requester k uses bits [k*W +: W].
- `i_req_B`  in  N*W  packed operand B, same packing.
- `o_req_ready`  out  N  one-hot grant/accept.
- `o_add_valid`  out  1  to adder valid input.
- `o_add_A`, `o_add_B`  out  W each  to adder operands.
- `i_add_valid`  in  1  adder result valid.
- `i_add_C`  in  W+1  adder sum.
- `o_rsp_valid`  out  1  response valid.
- `o_rsp_id`  out  IW  index of the served requester.
- `o_rsp_C`  out  W+1  captured sum.
- `o_rsp_err`  out  1  timeout flag.
- `i_rsp_ready`  in  1  response consumer ready.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Grant the first asserted `i_req_valid` searching from `last_grant+1` upward, modulo N.
  - `o_req_ready` is combinational and one-hot for that index. It is only nonzero in IDLE.
  - A request is accepted when valid and ready are both high in the same cycle.
  - On accept: latch A, B and ID; set `last_grant` to the granted index; go to ISSUE.
  - No valid request: stay in IDLE.
- **ISSUE:** `o_add_valid`=1 for exactly one cycle, with the latched operands on `o_add_A` and `o_add_B`; go to WAIT.
- **WAIT:**
  - On `i_add_valid`=1: capture `i_add_C` unmodified, set err=0, go to RESP.
  - Otherwise increment the watchdog counter.
  - When the counter reaches `g_timeout`: set C=0 and err=1, go to RESP.
  - The counter clears on entry to WAIT.
- **RESP:**
  - Hold `o_rsp_valid`=1 with stable `o_rsp_id`, `o_rsp_C` and `o_rsp_err` until `i_rsp_ready`=1.
  - On that cycle go to IDLE; `o_rsp_valid` drops the next cycle.
- `i_add_valid` is ignored outside WAIT.
- No new request is accepted while an operation is outstanding (IDLE only). The adder therefore never holds more than one operation.
- Requesters must hold `i_req_valid` and their operands stable until accepted. A requester that deasserts before its grant loses its turn without penalty.
- `o_add_A` and `o_add_B` hold the last latched values outside ISSUE; only `o_add_valid` qualifies them.
- Result range: 0 to 2·(2^W−1); for W=3 the maximum is 14. The arbiter never truncates or extends the sum.

## Timing
- Reset (`i_rst`=1 at a clock edge):
  - State goes to IDLE and `last_grant` to N−1, so index 0 has first priority.
  - Watchdog and latched operands clear.
  - All outputs are 0: `o_req_ready`, `o_add_valid`, `o_add_A`, `o_add_B`, `o_rsp_valid`, `o_rsp_id`, `o_rsp_C`, `o_rsp_err`.
  - `o_req_ready` is forced to 0 while `i_rst` is high.
- Reset mid-operation, in any state: the operation is discarded and no response is produced. The adder must share the same reset.
- Cycle sequence for an accept in cycle T:
  - T+1: `o_add_valid`=1.
  - T+2: adder `i_add_valid`=1.
  - T+3: `o_rsp_valid`=1.
- Accept-to-response latency is 3 cycles. With `i_rsp_ready` held high, the minimum issue interval is 4 cycles per operation.
- Timeout path: `o_rsp_valid`, with err=1, rises `g_timeout`+1 cycles after WAIT entry.
- A request arriving in the same cycle the FSM returns to IDLE is eligible next cycle; round-robin order is unaffected.

## Test plan
- **Reset:** all `i_req_valid`=1 while `i_rst`=1 for 3 cycles -> every output 0. After release the first grant is `o_req_ready`=4'b0001.
- **Single request:** requester 2 only, W=3, A=7, B=7, `i_rsp_ready`=1 -> `o_req_ready`=4'b0100 at T. At T+1: `o_add_valid`=1, `o_add_A`=7, `o_add_B`=7. At T+3: `o_rsp_valid`=1, id=2, C=14, err=0.
- **Fairness:** all 4 requesters continuously valid with distinct operands (k, k+1) -> grants 0,1,2,3,0 at 4-cycle spacing, response C values 1,3,5,7,1.
- **Backpressure:** `i_rsp_ready`=0 for 5 cycles during RESP -> `o_rsp_valid`, id and C stable; `o_req_ready`=0 and `o_add_valid`=0 throughout. Completion happens on the cycle ready rises.
- **Timeout:** adder stub never asserts `i_add_valid` -> response with err=1, C=0, correct id, 9 cycles after WAIT entry. A late stray `i_add_valid` while in RESP or IDLE is ignored.
- **Reset in WAIT:** assert `i_rst` one cycle after ISSUE -> no `o_rsp_valid` ever appears for that operation. The next grant goes to index 0 even if requester 3 was previously served.
